// File: rtl/serial_sub_ctrl_if.sv
// serial_sub_ctrl_if
//   Request/result bundle for the bit-serial subtractor controller.
//   Signals:
//     start  - request a subtraction (master -> slave)
//     a, b   - minuend / subtrahend, WIDTH bits (master -> slave)
//     busy   - high while the subtraction is running (slave -> master)
//     done   - one-cycle completion pulse (slave -> master)
//     dif    - a - b mod 2^WIDTH (slave -> master)
//     borrow - final borrow-out, set when a < b unsigned (slave -> master)
//   Modports: master (requester side), slave (serial_sub_ctrl side).
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dif;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, dif, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, dif, borrow
  );
endinterface

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
//   Bit-serial WIDTH-bit subtractor: dif = a - b, one bit per clock, LSB
//   first, through a single borrow-chained subtract cell (two half
//   subtractors plus an OR) and one borrow flip-flop.
//   Ports:
//     clk - rising-edge clock
//     rst - synchronous, active-high reset
//     bus - serial_sub_ctrl_if.slave (start, a, b in; busy, done, dif,
//           borrow out)
//   Sequence: IDLE --start--> RUN (WIDTH edges) --> DONE (1 cycle) --> IDLE.
//   dif/borrow are output registers updated only on the final RUN edge.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_sub_ctrl_if.slave   bus
);

  // Counter needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic [WIDTH-1:0] r_dif;
  logic             r_borrow;

  logic             w_ai;
  logic             w_bi;
  logic             w_hs1_d;
  logic             w_hs1_b;
  logic             w_hs2_b;
  logic             w_d;
  logic             w_bo;
  logic             w_last;
  logic [WIDTH-1:0] w_sr_next;

  // Subtract cell: first half subtractor on (ai, bi), second on
  // (ai^bi, br); the two borrows are ORed into the borrow-out.
  assign w_ai    = r_sa[0];
  assign w_bi    = r_sb[0];
  assign w_hs1_d = w_ai ^ w_bi;
  assign w_hs1_b = ~w_ai & w_bi;
  assign w_d     = w_hs1_d ^ r_br;
  assign w_hs2_b = ~w_hs1_d & r_br;
  assign w_bo    = w_hs1_b | w_hs2_b;

  assign w_last  = (r_cnt == LAST_BIT);

  // New difference bit enters at the MSB; after WIDTH shifts the first
  // (LSB) bit has reached position 0. A 1-bit result is just the bit.
  generate
    if (WIDTH == 1) begin : g_sr_w1
      assign w_sr_next = w_d;
    end else begin : g_sr_wn
      assign w_sr_next = {w_d, r_sr[WIDTH-1:1]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so it never queues.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.busy = (r_state == S_RUN);
    bus.done = (r_state == S_DONE);
  end

  assign bus.dif    = r_dif;
  assign bus.borrow = r_borrow;

  // Datapath: operand capture, shifting, borrow chain and result load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_sr     <= '0;
      r_cnt    <= '0;
      r_br     <= 1'b0;
      r_dif    <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sa  <= bus.a;
            r_sb  <= bus.b;
            r_sr  <= '0;
            r_cnt <= '0;
            r_br  <= 1'b0;
          end
        end
        S_RUN: begin
          r_sr  <= w_sr_next;
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_br  <= w_bo;
          r_cnt <= r_cnt + 1'b1;
          // Results stay frozen until the final bit of the next operation.
          if (w_last) begin
            r_dif    <= w_sr_next;
            r_borrow <= w_bo;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.WIDTH(8)) if8 ();
  serial_sub_ctrl_if #(.WIDTH(4)) if4 ();
  serial_sub_ctrl_if #(.WIDTH(1)) if1 ();

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  serial_sub_ctrl #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  serial_sub_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  int n_checks = 0;
  int n_errors = 0;

  // Last result each instance should be holding, indexed by width.
  logic [31:0] prev_dif [0:8];
  logic        prev_bor [0:8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic get_busy(input int sel);
    case (sel)
      8:       return if8.busy;
      4:       return if4.busy;
      default: return if1.busy;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      8:       return if8.done;
      4:       return if4.done;
      default: return if1.done;
    endcase
  endfunction

  function automatic logic [31:0] get_dif(input int sel);
    case (sel)
      8:       return 32'(if8.dif);
      4:       return 32'(if4.dif);
      default: return 32'(if1.dif);
    endcase
  endfunction

  function automatic logic get_bor(input int sel);
    case (sel)
      8:       return if8.borrow;
      4:       return if4.borrow;
      default: return if1.borrow;
    endcase
  endfunction

  task automatic drive(input int sel, input logic s, input logic [31:0] a, input logic [31:0] b);
    case (sel)
      8: begin if8.start = s; if8.a = a[7:0]; if8.b = b[7:0]; end
      4: begin if4.start = s; if4.a = a[3:0]; if4.b = b[3:0]; end
      default: begin if1.start = s; if1.a = a[0:0]; if1.b = b[0:0]; end
    endcase
  endtask

  task automatic clear_prev();
    for (int i = 0; i <= 8; i++) begin
      prev_dif[i] = '0;
      prev_bor[i] = 1'b0;
    end
  endtask

  // One operation on instance 'sel'; inputs are scrambled and start is
  // pulsed randomly while it runs to show neither affects the result.
  task automatic run_op(input int sel, input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] mask;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_d;
    logic        exp_b;
    int          cycles;
    mask  = (32'd1 << sel) - 32'd1;
    a     = a_in & mask;
    b     = b_in & mask;
    exp_d = (a - b) & mask;
    exp_b = (a < b);
    @(negedge clk);
    drive(sel, 1'b1, a, b);
    @(posedge clk);
    #1;
    drive(sel, 1'($urandom_range(0, 1)), $urandom, $urandom);
    cycles = 0;
    @(negedge clk);
    while (get_busy(sel) && cycles < 100) begin
      cycles++;
      check("run_no_done", 32'(get_done(sel)), 32'd0);
      check("run_hold_dif", get_dif(sel), prev_dif[sel]);
      check("run_hold_borrow", 32'(get_bor(sel)), 32'(prev_bor[sel]));
      drive(sel, 1'($urandom_range(0, 1)), $urandom, $urandom);
      @(negedge clk);
    end
    check("busy_cycles", 32'(cycles), 32'(sel));
    check("done_pulse", 32'(get_done(sel)), 32'd1);
    check("busy_in_done", 32'(get_busy(sel)), 32'd0);
    check("dif", get_dif(sel), exp_d);
    check("borrow", 32'(get_bor(sel)), 32'(exp_b));
    $display("W=%0d a=%0h b=%0h dif=%0h borrow=%0b (exp %0h/%0b) busy_cycles=%0d",
             sel, a, b, get_dif(sel), get_bor(sel), exp_d, exp_b, cycles);
    prev_dif[sel] = exp_d;
    prev_bor[sel] = exp_b;
    // start on the DONE->IDLE edge must be ignored
    drive(sel, 1'($urandom_range(0, 1)), $urandom, $urandom);
    @(negedge clk);
    check("idle_busy", 32'(get_busy(sel)), 32'd0);
    check("idle_done", 32'(get_done(sel)), 32'd0);
    check("idle_hold_dif", get_dif(sel), prev_dif[sel]);
    check("idle_hold_borrow", 32'(get_bor(sel)), 32'(prev_bor[sel]));
    drive(sel, 1'b0, $urandom, $urandom);
    @(negedge clk);
    check("not_queued", 32'(get_busy(sel)), 32'd0);
  endtask

  initial begin
    int idx;
    int since;
    int budget;
    int dones;
    bit first;
    logic [31:0] sa;
    logic [31:0] sb;

    rst = 1'b1;
    drive(8, 1'b0, 0, 0);
    drive(4, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    clear_prev();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      int sel;
      sel = (s == 0) ? 8 : ((s == 1) ? 4 : 1);
      check("reset_busy", 32'(get_busy(sel)), 32'd0);
      check("reset_done", 32'(get_done(sel)), 32'd0);
      check("reset_dif", get_dif(sel), 32'd0);
      check("reset_borrow", 32'(get_bor(sel)), 32'd0);
    end

    // Directed WIDTH=8 cases
    run_op(8, 32'd5, 32'd3);
    run_op(8, 32'd3, 32'd5);
    run_op(8, 32'h00, 32'h01);
    run_op(8, 32'hA5, 32'hA5);
    // Randomized WIDTH=8
    for (int i = 0; i < 20; i++) begin
      run_op(8, $urandom, $urandom);
    end
    run_op(8, 32'hFF, 32'h00);

    // WIDTH=4 exhaustive sweep with start held high
    idx = 0;
    since = 0;
    budget = 0;
    first = 1'b1;
    @(negedge clk);
    drive(4, 1'b1, 32'(idx >> 4), 32'(idx & 15));
    while (idx < 256 && budget < 2000) begin
      @(negedge clk);
      budget++;
      since++;
      check("busy_done_excl", 32'(if4.busy & if4.done), 32'd0);
      if (if4.done) begin
        sa = 32'(idx >> 4);
        sb = 32'(idx & 15);
        check("sweep_dif", get_dif(4), (sa - sb) & 32'hF);
        check("sweep_borrow", 32'(get_bor(4)), 32'(sa < sb));
        if (!first) check("sweep_period", 32'(since), 32'd6);
        $display("W=4 sweep a=%0h b=%0h dif=%0h borrow=%0b period=%0d",
                 sa, sb, get_dif(4), get_bor(4), since);
        first = 1'b0;
        since = 0;
        prev_dif[4] = (sa - sb) & 32'hF;
        prev_bor[4] = (sa < sb);
        idx++;
        drive(4, 1'b1, 32'(idx >> 4), 32'(idx & 15));
      end
    end
    drive(4, 1'b0, 0, 0);
    check("sweep_count", 32'(idx), 32'd256);
    repeat (3) @(negedge clk);
    check("sweep_idle", 32'(if4.busy | if4.done), 32'd0);

    // Reset during RUN on the 4th RUN cycle
    run_op(8, 32'h10, 32'h01);
    @(negedge clk);
    drive(8, 1'b1, 32'h40, 32'h03);
    @(posedge clk);
    #1 drive(8, 1'b0, 0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(if8.busy), 32'd0);
    check("rst_done", 32'(if8.done), 32'd0);
    check("rst_dif", 32'(if8.dif), 32'd0);
    check("rst_borrow", 32'(if8.borrow), 32'd0);
    $display("W=8 reset mid-run: busy=%0b done=%0b dif=%0h borrow=%0b",
             if8.busy, if8.done, if8.dif, if8.borrow);
    clear_prev();
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if8.done || if8.busy) dones++;
    end
    check("no_done_after_rst", 32'(dones), 32'd0);
    // rst and start on the same edge: rst wins
    rst = 1'b1;
    drive(8, 1'b1, 32'h22, 32'h11);
    @(posedge clk);
    #1 begin
      rst = 1'b0;
      drive(8, 1'b0, 0, 0);
    end
    @(negedge clk);
    check("rst_over_start", 32'(if8.busy), 32'd0);
    @(negedge clk);
    check("rst_over_start_idle", 32'(if8.busy | if8.done), 32'd0);
    $display("W=8 rst+start same edge: busy=%0b done=%0b", if8.busy, if8.done);

    // Fresh operation after reset uses new operands
    run_op(8, 32'h81, 32'h7F);

    // WIDTH=1 all combinations
    run_op(1, 32'd0, 32'd0);
    run_op(1, 32'd0, 32'd1);
    run_op(1, 32'd1, 32'd0);
    run_op(1, 32'd1, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute watchdog so the run cannot hang.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
